// File: rtl/alu32_stage.sv
// Registered 32-bit ALU execute stage with valid/ready handshakes on both sides.
// Logic ops and add/sub finish in one cycle; shifts run one bit per cycle.

module xor32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

module alu32_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        zero,
  output logic        carry
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA
  } op_t;

  state_t      state_q;
  op_t         op_q;
  op_t         op_dec;
  logic [4:0]  cnt_q;
  logic [31:0] y_q;
  logic        zero_q, carry_q, in_ready_q, out_valid_q;

  logic [31:0] xor_y, add_b, res_d, sh_y;
  logic [32:0] sum;
  logic        res_c, sh_c, is_sub, is_shift;

  xor32 u_xor (.a(a), .b(b), .y(xor_y));

  assign op_dec   = op_t'(op);
  assign is_sub   = (op_dec == OP_SUB);
  assign is_shift = (op_dec == OP_SLL) || (op_dec == OP_SRL) || (op_dec == OP_SRA);
  // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  assign add_b    = is_sub ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, add_b} + {32'b0, is_sub};

  always_comb begin
    res_d = a;
    res_c = 1'b0;
    case (op_dec)
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = xor_y;
      OP_ADD,
      OP_SUB:  begin res_d = sum[31:0]; res_c = sum[32]; end
      default: begin res_d = a; res_c = 1'b0; end
    endcase
  end

  // y_q doubles as the shift working register while in SHIFT.
  always_comb begin
    sh_y = y_q;
    sh_c = 1'b0;
    case (op_q)
      OP_SLL:  begin sh_y = {y_q[30:0], 1'b0};   sh_c = y_q[31]; end
      OP_SRL:  begin sh_y = {1'b0, y_q[31:1]};   sh_c = y_q[0];  end
      OP_SRA:  begin sh_y = {y_q[31], y_q[31:1]}; sh_c = y_q[0]; end
      default: begin sh_y = y_q; sh_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      cnt_q       <= '0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            op_q       <= op_dec;
            if (is_shift && (b[4:0] != 5'd0)) begin
              y_q     <= a;
              cnt_q   <= b[4:0];
              state_q <= SHIFT;
            end else begin
              y_q         <= res_d;
              carry_q     <= res_c;
              zero_q      <= (res_d == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          y_q     <= sh_y;
          carry_q <= sh_c;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            zero_q      <= (sh_y == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
endmodule

// File: tb/tb_alu32_stage.sv
// Self-checking bench for alu32_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model.

module tb_alu32_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        zero;
  logic        carry;

  int checks = 0;
  int errors = 0;

  alu32_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit windows let the shifted-out bit fall next to the result.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] v,
                                output logic [31:0] ry, output logic rc, output int lat);
    logic [32:0] s;
    logic [63:0] w;
    int n;
    n   = int'(v[4:0]);
    lat = 1;
    rc  = 1'b0;
    ry  = x;
    case (o)
      3'd0: ry = x & v;
      3'd1: ry = x | v;
      3'd2: ry = x ^ v;
      3'd3: begin s = {1'b0, x} + {1'b0, v}; ry = s[31:0]; rc = s[32]; end
      3'd4: begin s = {1'b0, x} + {1'b0, ~v} + 33'd1; ry = s[31:0]; rc = s[32]; end
      3'd5: begin w = {32'b0, x} << n; ry = w[31:0]; rc = (n > 0) ? w[32] : 1'b0; lat = 1 + n; end
      3'd6: begin w = {x, 32'b0} >> n; ry = w[63:32]; rc = (n > 0) ? w[31] : 1'b0; lat = 1 + n; end
      default: begin
        w = $signed({x, 32'b0}) >>> n; ry = w[63:32]; rc = (n > 0) ? w[31] : 1'b0; lat = 1 + n;
      end
    endcase
  endfunction

  // Drives one op, returns observed result and latency counted from the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] v,
                        output logic [31:0] ry, output logic rz, output logic rc,
                        output int lat, output bit to);
    int n;
    to = 0; lat = 0; ry = '0; rz = 1'b0; rc = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin to = 1; return; end
    op = o; a = x; b = v; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) to = 1;
    ry = y; rz = zero; rc = carry;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, y, zero, carry} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b y=%h z=%b c=%b, want all 0", out_valid, in_ready, y, zero, carry);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed(input string nm, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] v, input logic [31:0] ey, input logic ez,
                               input logic ec, input int el);
    logic [31:0] ry; logic rz, rc; int lat; bit to;
    run_op(o, x, v, ry, rz, rc, lat, to);
    checks++;
    if (to || ry !== ey || rz !== ez || rc !== ec || lat != el) begin
      errors++;
      $display("FAIL %s: y=%h z=%b c=%b lat=%0d to=%0d, want y=%h z=%b c=%b lat=%0d",
               nm, ry, rz, rc, lat, to, ey, ez, ec, el);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] ry; logic rz, rc; int lat; bit to;
    run_op(3'd2, 32'hFFFF_FFFC, 32'h4, ry, rz, rc, lat, to);
    in_valid = 1'b1; op = 3'd3; a = 32'h1; b = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (to || y !== 32'hFFFF_FFF8 || zero !== 1'b0 || carry !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: y=%h z=%b c=%b ir=%b ov=%b, want y=fffffff8 z=0 c=0 ir=0 ov=1",
                 i, y, zero, carry, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midshift();
    bit seen;
    logic [31:0] ry; logic rz, rc; int lat; bit to;
    seen = 0;
    op = 3'd5; a = 32'h1; b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin @(negedge clk); if (out_valid === 1'b1) seen = 1; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (seen || out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_midshift: early_ov=%0d ov=%b y=%h ir=%b, want 0 0 00000000 0", seen, out_valid, y, in_ready);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: ov=%b want 0", out_valid); end
    run_op(3'd3, 32'd2, 32'd2, ry, rz, rc, lat, to);
    checks++;
    if (to || ry !== 32'd4 || rz !== 1'b0 || rc !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL post_reset_add: y=%h z=%b c=%b lat=%0d, want y=00000004 z=0 c=0 lat=1", ry, rz, rc, lat);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [2:0] o; logic [31:0] x, v, ey, ry, hy; logic ec, rz, rc; int el, lat, d; bit to;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7)); x = $urandom; v = $urandom;
      if ($urandom_range(0, 3) == 0) v = v & 32'h3;
      if ($urandom_range(0, 5) == 0) v = x;
      model(o, x, v, ey, ec, el);
      run_op(o, x, v, ry, rz, rc, lat, to);
      checks++;
      if (to || ry !== ey || rc !== ec || rz !== (ey == 32'd0) || lat != el) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: y=%h z=%b c=%b lat=%0d, want y=%h z=%b c=%b lat=%0d",
                 i, o, x, v, ry, rz, rc, lat, ey, (ey == 32'd0), ec, el);
      end
      hy = y;
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      checks++;
      if (y !== hy || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL random_hold[%0d]: y=%h ov=%b, want y=%h ov=1", i, y, out_valid, hy);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed("xor",       3'd2, 32'hFFFF_FFFC, 32'h0000_0004, 32'hFFFF_FFF8, 1'b0, 1'b0, 1);
    test_directed("add_wrap",  3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
    test_directed("sub_borrow",3'd4, 32'd3,         32'd4,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    test_directed("sub_equal", 3'd4, 32'd4,         32'd4,         32'h0000_0000, 1'b1, 1'b1, 1);
    test_directed("and",       3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1);
    test_directed("or",        3'd1, 32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0, 1'b0, 1);
    test_directed("sra4",      3'd7, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 5);
    test_directed("sll1",      3'd5, 32'h8000_0001, 32'd1,         32'h0000_0002, 1'b0, 1'b1, 2);
    test_directed("srl_amt0",  3'd6, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1);
    test_directed("srl31",     3'd6, 32'hC000_0000, 32'd31,        32'h0000_0001, 1'b0, 1'b1, 32);
    test_backpressure();
    test_reset_midshift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
